// File: rtl/j1_boot_pkg.sv
// j1_boot_pkg: FSM state codes and image framing constants shared by the J1 boot loader.
// The CKSUM state exists only when J1_BOOT_CHECKSUM_EN is defined.
package j1_boot_pkg;

  typedef logic [2:0] state_t;

  localparam state_t HDR_LO = 3'd0;
  localparam state_t HDR_HI = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t FLUSH  = 3'd3;
  localparam state_t RUN    = 3'd4;
  localparam state_t ERR    = 3'd5;
`ifdef J1_BOOT_CHECKSUM_EN
  localparam state_t CKSUM  = 3'd6;
`endif

  localparam int WORD_BYTES = 3;
  localparam int HDR_BYTES  = 2;

  function automatic logic takes_bytes(input state_t s);
    logic r;
    case (s)
      HDR_LO, HDR_HI, DATA: r = 1'b1;
`ifdef J1_BOOT_CHECKSUM_EN
      CKSUM: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/j1_boot_loader.sv
// j1_boot_loader: loads a length-prefixed 18-bit image from a byte stream into J1 code RAM,
// holding the core in reset until done. J1_BOOT_CHECKSUM_EN appends a trailing checksum byte.
module j1_boot_loader
  import j1_boot_pkg::*;
#(
  parameter int CODE_AW = 13
) (
  input  logic               clk,
  input  logic               resetq,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  input  logic               load_req,
  output logic               cpu_resetq,
  output logic               code_we,
  output logic [CODE_AW-1:0] code_waddr,
  output logic [17:0]        code_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);
  localparam int unsigned MAX_WORDS = 32'd1 << CODE_AW;

  state_t               state_r, state_s;
  logic [7:0]           n_lo_r;
  logic [15:0]          n_r;
  logic [15:0]          n_s;
  logic [1:0]           byte_cnt_r;
  logic [CODE_AW-1:0]   word_cnt_r;
  logic [7:0]           b0_r, b1_r;
  logic                 code_we_r;
  logic [CODE_AW-1:0]   code_waddr_r;
  logic [17:0]          code_wdata_r;
  logic                 cpu_resetq_r, busy_r, done_r, err_r, rx_ready_r;
  logic                 hs_s, too_big_s, last_word_s;

  assign hs_s        = rx_valid & rx_ready_r;
  assign n_s         = {rx_data, n_lo_r};
  assign too_big_s   = ({16'd0, n_s} > MAX_WORDS);
  assign last_word_s = ({16'd0, n_r} == (32'(word_cnt_r) + 32'd1));

`ifdef J1_BOOT_CHECKSUM_EN
  logic [7:0] sum_r, sum_s;
  assign sum_s = sum_r + rx_data;

  // Running sum over every accepted byte, restarted with each load.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sum_r <= 8'd0;
    end else if (load_req) begin
      sum_r <= 8'd0;
    end else if (hs_s) begin
      sum_r <= sum_s;
    end
  end
`endif

  // Next-state selection; load_req overrides everything, including a same-cycle byte.
  always_comb begin
    state_s = state_r;
    if (load_req) begin
      state_s = HDR_LO;
    end else begin
      case (state_r)
        HDR_LO: begin
          if (hs_s) state_s = HDR_HI;
          else      state_s = HDR_LO;
        end
        HDR_HI: begin
          if (!hs_s)               state_s = HDR_HI;
          else if (n_s == 16'd0)   state_s = FLUSH;
          else if (too_big_s)      state_s = ERR;
          else                     state_s = DATA;
        end
        DATA: begin
          if (hs_s && (byte_cnt_r == LAST_BYTE) && last_word_s) state_s = FLUSH;
          else                                                    state_s = DATA;
        end
`ifdef J1_BOOT_CHECKSUM_EN
        FLUSH: state_s = CKSUM;
        CKSUM: begin
          if (!hs_s)               state_s = CKSUM;
          else if (sum_s == 8'd0)  state_s = RUN;
          else                     state_s = ERR;
        end
`else
        FLUSH: state_s = RUN;
`endif
        RUN:     state_s = RUN;
        ERR:     state_s = ERR;
        default: state_s = HDR_LO;
      endcase
    end
  end

  // State register and state-decoded outputs, all registered from the next state.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_r      <= HDR_LO;
      cpu_resetq_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b1;
      err_r        <= 1'b0;
      rx_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_s;
      cpu_resetq_r <= (state_s == RUN);
      done_r       <= (state_s == RUN);
      busy_r       <= (state_s != RUN) && (state_s != ERR);
      err_r        <= (state_s == ERR);
      rx_ready_r   <= takes_bytes(state_s);
    end
  end

  // Header capture, byte-to-word packing and the one-cycle code-RAM write strobe.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      n_lo_r       <= 8'd0;
      n_r          <= 16'd0;
      byte_cnt_r   <= 2'd0;
      word_cnt_r   <= {CODE_AW{1'b0}};
      b0_r         <= 8'd0;
      b1_r         <= 8'd0;
      code_we_r    <= 1'b0;
      code_waddr_r <= {CODE_AW{1'b0}};
      code_wdata_r <= 18'd0;
    end else begin
      code_we_r <= 1'b0;
      if (load_req) begin
        byte_cnt_r <= 2'd0;
        word_cnt_r <= {CODE_AW{1'b0}};
      end else if (hs_s) begin
        case (state_r)
          HDR_LO: n_lo_r <= rx_data;
          HDR_HI: begin
            n_r        <= n_s;
            byte_cnt_r <= 2'd0;
            word_cnt_r <= {CODE_AW{1'b0}};
          end
          DATA: begin
            if (byte_cnt_r == LAST_BYTE) begin
              code_we_r    <= 1'b1;
              code_waddr_r <= word_cnt_r;
              code_wdata_r <= {rx_data[1:0], b1_r, b0_r};
              byte_cnt_r   <= 2'd0;
              // Stop at the last word so the index never wraps.
              if (!last_word_s) word_cnt_r <= word_cnt_r + CODE_AW'(1);
            end else begin
              if (byte_cnt_r == 2'd0) b0_r <= rx_data;
              else                    b1_r <= rx_data;
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready   = rx_ready_r;
  assign cpu_resetq = cpu_resetq_r;
  assign code_we    = code_we_r;
  assign code_waddr = code_waddr_r;
  assign code_wdata = code_wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: doc/j1_boot_loader.md
J1_BOOT_LOADER -- requirements
Module: j1_boot_loader

Interface
REQ-001 Parameter CODE_AW, default 13, SHALL set the code-RAM word-address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetq  input  1  reset, asynchronous, active-low.
REQ-004 rx_valid  input  1  byte-stream valid, from the UART receiver.
REQ-005 rx_data  input  8  byte-stream data.
REQ-006 rx_ready  output  1  loader accepts a byte when rx_valid&rx_ready.
REQ-007 load_req  input  1  single-cycle pulse that restarts loading.
REQ-008 cpu_resetq  output  1  active-low reset to the J1 core, registered.
REQ-009 code_we  output  1  code-RAM write strobe.
REQ-010 code_waddr  output  CODE_AW  code-RAM write address.
REQ-011 code_wdata  output  18  instruction word.
REQ-012 busy  output  1  loading in progress.
REQ-013 done  output  1  CPU released.
REQ-014 err  output  1  load failed.

Function
REQ-015 The image stream SHALL be: count N (2 bytes, LSB first), then N words of 3 bytes each, LSB first; code_wdata = {b2[1:0], b1, b0}, and b2[7:2] is ignored.
REQ-016 The FSM SHALL use states HDR_LO, HDR_HI, DATA, FLUSH, CKSUM (only with the macro), RUN and ERR.
REQ-017 rx_ready SHALL be 1 only in HDR_LO, HDR_HI, DATA and CKSUM.
REQ-018 HDR_LO SHALL go to HDR_HI on a handshake; HDR_HI SHALL go, on a handshake, as follows:
- N=0 goes to FLUSH.
- N>2^CODE_AW goes to ERR.
- Otherwise it goes to DATA.
REQ-019 DATA SHALL count bytes 0..2 and count words from 0. On the third byte's handshake it SHALL register the word, and code_we SHALL be 1 for exactly the next cycle, with code_waddr equal to the word index.
REQ-020 After the handshake of the byte that completes word N-1, DATA SHALL go to FLUSH; FLUSH SHALL last one cycle, so the final write completes before release.
REQ-021 FLUSH SHALL go to RUN, or to CKSUM when the macro is defined.
REQ-022 In RUN, cpu_resetq, done = 1 and busy = 0; in every other state, cpu_resetq = 0.
REQ-023 cpu_resetq SHALL rise on the clock edge that enters RUN, which is at least 2 cycles after the last byte handshake.
REQ-024 ERR SHALL hold err = 1, rx_ready = 0 and cpu_resetq = 0 until load_req.
REQ-025 A load_req in any state SHALL take effect as follows:
- The next state is HDR_LO.
- The word and byte counters clear.
- Any partial word and any pending code_we are discarded.
- err clears.
- cpu_resetq is 0 from the next cycle.
- load_req takes priority over a same-cycle byte handshake, and that byte is dropped.
REQ-026 rx_valid gaps of any length SHALL NOT alter state, counters or outputs.
REQ-027 Word addresses SHALL never wrap, because N is bounded by REQ-018.

Reset
REQ-028 When resetq is asserted, the block SHALL enter HDR_LO with the following outputs, all asynchronously: cpu_resetq=0, code_we=0, code_waddr=0, code_wdata=0, err=0, done=0, busy=1, rx_ready=1.
REQ-029 Deasserting resetq mid-load SHALL restart at HDR_LO, discarding everything received before.

Configuration
REQ-030 The macro J1_BOOT_CHECKSUM_EN SHALL compile in CKSUM: an 8-bit running sum covers all header, data and checksum bytes.
REQ-031 With J1_BOOT_CHECKSUM_EN defined, CKSUM SHALL accept one byte; a final sum of 0x00 goes to RUN, and any other sum goes to ERR.
REQ-032 Without J1_BOOT_CHECKSUM_EN, the CKSUM state and the running-sum register SHALL be absent, and FLUSH SHALL go directly to RUN.

Structure
REQ-033 The shared package j1_boot_pkg SHALL hold the state enum, WORD_BYTES=3 and the header length 2.
REQ-034 No sub-module is required; the byte-to-word packer SHALL be inline registers.

Verification
REQ-035 With the macro off, bytes 02 00 34 12 02 CD AB 01 -> code_we writes 0x21234 to address 0 and 0x1ABCD to address 1; cpu_resetq rises 2 cycles after the 0x01 handshake.
REQ-036 Bytes 00 00 -> no code_we, FLUSH for one cycle, then done=1 and cpu_resetq=1.
REQ-037 Bytes 01 20 (N=8193) -> err=1, rx_ready=0, cpu_resetq stays 0; a load_req pulse -> err=0 and rx_ready=1 next cycle.
REQ-038 With the macro on, the stream of REQ-035 plus byte 3D -> RUN; plus byte 3E instead -> ERR with no release.
REQ-039 A load_req after byte 34, then 01 00 56 34 FF -> a single write of 0x33456 to address 0, then RUN.
REQ-040 A load_req in RUN -> cpu_resetq=0 next cycle; resetq pulsed low mid-DATA -> all outputs at their reset values immediately, then a clean reload from HDR_LO.
